// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding, load-use stall,
// data-memory freeze and multi-cycle branch flush. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned AW          = 5,
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC*AW-1:0]   ex_rs_addr,
  input  logic [NUM_SRC-1:0]      ex_rs_used,
  input  logic [AW-1:0]           mem_rd_addr,
  input  logic                    mem_reg_wr,
  input  logic                    mem_is_load,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  input  logic [AW-1:0]           wb_rd_addr,
  input  logic                    wb_reg_wr,
  input  logic                    br_taken,
  output logic [2*NUM_SRC-1:0]    fwd_sel,
  output logic                    stall_if,
  output logic                    stall_dec,
  output logic                    stall_ex,
  output logic                    stall_mem,
  output logic                    bubble_mem,
  output logic                    bubble_wb,
  output logic                    if_flush,
  output logic                    dec_flush,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int unsigned FCW = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [FCW-1:0]     fcnt, fcnt_nxt;
  logic [2*NUM_SRC-1:0] fwd;
  logic               mem_hit;
  logic               freeze;
  logic               load_use;
  logic               br_acc;

  // Per-operand forward select; MEM result is newer than WB so it wins.
  always_comb begin
    logic [AW-1:0] src;
    fwd     = '0;
    mem_hit = 1'b0;
    src     = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src = ex_rs_addr[i*AW +: AW];
      if (ex_rs_used[i] && (src != '0)) begin
        if (mem_reg_wr && (src == mem_rd_addr)) begin
          fwd[2*i +: 2] = 2'b01;
          mem_hit       = 1'b1;
        end else if (wb_reg_wr && (src == wb_rd_addr)) begin
          fwd[2*i +: 2] = 2'b10;
        end
      end
    end
  end

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = ~freeze & mem_is_load & mem_hit;
  assign br_acc   = br_taken & ~freeze & ~load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Outputs are forced to their reset values while rst_n is low.
  always_comb begin
    state_nxt  = state;
    fcnt_nxt   = fcnt;
    fwd_sel    = '0;
    stall_if   = 1'b0;
    stall_dec  = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    bubble_mem = 1'b0;
    bubble_wb  = 1'b0;
    if_flush   = 1'b0;
    dec_flush  = 1'b0;
    if (rst_n) begin
      fwd_sel = fwd;
      if (freeze) begin
        stall_if  = 1'b1;
        stall_dec = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        bubble_wb = 1'b1;
      end else begin
        if (load_use) begin
          stall_if   = 1'b1;
          stall_dec  = 1'b1;
          stall_ex   = 1'b1;
          bubble_mem = 1'b1;
        end
        case (state)
          IDLE: begin
            if (br_acc) begin
              if_flush  = 1'b1;
              dec_flush = 1'b1;
              if (FLUSH_EXTRA != 0) begin
                fcnt_nxt  = FCW'(FLUSH_EXTRA);
                state_nxt = FLUSH;
              end
            end
          end
          FLUSH: begin
            if_flush = 1'b1;
            // A new redirect restarts the extra-flush window.
            if (br_acc) begin
              dec_flush = 1'b1;
              fcnt_nxt  = FCW'(FLUSH_EXTRA);
            end else begin
              fcnt_nxt = FCW'(fcnt - FCW'(1));
              if (fcnt == FCW'(1)) state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_if | stall_dec | stall_ex | stall_mem) stall_q <= stall_q + CNT_W'(1);
      if (br_acc) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a remaining-flush-cycles model checked every negedge.
module tb_hazard_ctrl;

  localparam int unsigned NS = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned FE = 2;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS*AW-1:0] ex_rs_addr;
  logic [NS-1:0] ex_rs_used;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_reg_wr, mem_is_load, mem_req, mem_ready;
  logic [AW-1:0] wb_rd_addr;
  logic          wb_reg_wr, br_taken;
  logic [2*NS-1:0] fwd_sel;
  logic          stall_if, stall_dec, stall_ex, stall_mem;
  logic          bubble_mem, bubble_wb, if_flush, dec_flush;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int errors  = 0;

  hazard_ctrl #(.NUM_SRC(NS), .AW(AW), .FLUSH_EXTRA(FE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_rs_addr(ex_rs_addr), .ex_rs_used(ex_rs_used),
    .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr), .mem_is_load(mem_is_load),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_rd_addr(wb_rd_addr), .wb_reg_wr(wb_reg_wr),
    .br_taken(br_taken), .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_dec(stall_dec),
    .stall_ex(stall_ex), .stall_mem(stall_mem), .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
    .if_flush(if_flush), .dec_flush(dec_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: number of IF-flush cycles still owed after the current one.
  int            left;
  logic [CW-1:0] m_stall_cnt, m_flush_cnt;
  logic [3:0]    m_fwd;
  logic          m_fz, m_lu, m_acc, m_stall;

  always_comb begin
    logic [AW-1:0] a;
    m_fwd = '0;
    a     = '0;
    for (int i = 0; i < 2; i++) begin
      a = ex_rs_addr[i*5 +: 5];
      if (rst_n && ex_rs_used[i] && a != 0) begin
        if (mem_reg_wr && a == mem_rd_addr)     m_fwd[2*i +: 2] = 2'd1;
        else if (wb_reg_wr && a == wb_rd_addr)  m_fwd[2*i +: 2] = 2'd2;
      end
    end
    m_fz    = rst_n && mem_req && !mem_ready;
    m_lu    = rst_n && !m_fz && mem_is_load && (m_fwd[1:0] == 2'd1 || m_fwd[3:2] == 2'd1);
    m_acc   = rst_n && br_taken && !m_fz && !m_lu;
    m_stall = m_fz || m_lu;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left        <= 0;
      m_stall_cnt <= '0;
      m_flush_cnt <= '0;
    end else begin
      if (m_stall) m_stall_cnt <= m_stall_cnt + 1;
      if (m_acc)   m_flush_cnt <= m_flush_cnt + 1;
      if (!m_fz) begin
        if (m_acc)         left <= FE;
        else if (left > 0) left <= left - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_fwd_sel",   32'(fwd_sel),   32'(m_fwd));
    chk("m_stall_if",  32'(stall_if),  32'(m_stall));
    chk("m_stall_dec", 32'(stall_dec), 32'(m_stall));
    chk("m_stall_ex",  32'(stall_ex),  32'(m_stall));
    chk("m_stall_mem", 32'(stall_mem), 32'(m_fz));
    chk("m_bubble_mem",32'(bubble_mem),32'(m_lu));
    chk("m_bubble_wb", 32'(bubble_wb), 32'(m_fz));
    chk("m_if_flush",  32'(if_flush),  32'(rst_n && !m_fz && (left > 0 || m_acc)));
    chk("m_dec_flush", 32'(dec_flush), 32'(m_acc));
`ifdef HAZARD_PERF_EN
    chk("m_stall_cnt", stall_cnt, m_stall_cnt);
    chk("m_flush_cnt", flush_cnt, m_flush_cnt);
`else
    chk("m_stall_cnt", stall_cnt, 32'd0);
    chk("m_flush_cnt", flush_cnt, 32'd0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ex_rs_addr = '0; ex_rs_used = '0; mem_rd_addr = '0; mem_reg_wr = 1'b0;
    mem_is_load = 1'b0; mem_req = 1'b0; mem_ready = 1'b1; wb_rd_addr = '0;
    wb_reg_wr = 1'b0; br_taken = 1'b0;
  endtask

  task automatic set_rs(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] used);
    ex_rs_addr = {r2, r1};
    ex_rs_used = used;
  endtask

  task automatic chk_flush(input string nm, input logic ei, input logic ed);
    chk({nm, "_if"},  32'(if_flush),  32'(ei));
    chk({nm, "_dec"}, 32'(dec_flush), 32'(ed));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] s0, f0;
    clear();
    rst_n = 1'b0;
    // Active inputs during reset must not leak to the outputs.
    set_rs(5'd5, 5'd7, 2'b11); mem_rd_addr = 5'd5; mem_reg_wr = 1'b1; br_taken = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0;
    #2;
    chk("rst_fwd",   32'(fwd_sel),   32'h0);
    chk("rst_stall", 32'(stall_mem), 32'h0);
    chk("rst_bwb",   32'(bubble_wb), 32'h0);
    chk_flush("rst", 1'b0, 1'b0);
    step(); step();
    clear(); rst_n = 1'b1;
    #1 chk_flush("idle", 1'b0, 1'b0);

    // 1: MEM forward, ALU result, no stall
    step(); set_rs(5'd5, 5'd0, 2'b01); mem_rd_addr = 5'd5; mem_reg_wr = 1'b1;
    #1 chk("t1_fwd", 32'(fwd_sel), 32'h1); chk("t1_stall", 32'(stall_if), 32'h0);

    // 2: load-use on rs2, then WB forward next cycle
    step(); set_rs(5'd0, 5'd7, 2'b10); mem_rd_addr = 5'd7; mem_is_load = 1'b1;
    #1 chk("t2_fwd", 32'(fwd_sel), 32'h4);
    chk("t2_stall", 32'({stall_if, stall_dec, stall_ex, stall_mem, bubble_mem}), 32'b11101);
    step(); mem_reg_wr = 1'b0; mem_is_load = 1'b0; wb_rd_addr = 5'd7; wb_reg_wr = 1'b1;
    #1 chk("t2_wbfwd", 32'(fwd_sel), 32'h8); chk("t2_nostall", 32'(stall_if), 32'h0);

    // 3: x0 never forwards; MEM beats WB; WB-only; unused operand
    step(); clear(); set_rs(5'd0, 5'd0, 2'b01); mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
    #1 chk("t3_x0", 32'(fwd_sel), 32'h0);
    set_rs(5'd3, 5'd3, 2'b11); mem_rd_addr = 5'd3; wb_rd_addr = 5'd3;
    #1 chk("t3_both", 32'(fwd_sel), 32'h5);
    mem_reg_wr = 1'b0;
    #1 chk("t3_wb", 32'(fwd_sel), 32'hA);
    ex_rs_used = 2'b00;
    #1 chk("t3_unused", 32'(fwd_sel), 32'h0);

    // 4: taken branch, FLUSH_EXTRA=2
    step(); clear(); f0 = flush_cnt; br_taken = 1'b1;
    #1 chk_flush("t4_c0", 1'b1, 1'b1);
    step(); br_taken = 1'b0;
    #1 chk_flush("t4_c1", 1'b1, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("t4_fcnt", flush_cnt, f0 + 1);
`endif
    step(); #1 chk_flush("t4_c2", 1'b1, 1'b0);
    step(); #1 chk_flush("t4_c3", 1'b0, 1'b0);

    // 5: freeze for 3 cycles inside FLUSH, branch ignored, counter held
    br_taken = 1'b1;
    #1 chk_flush("t5_br", 1'b1, 1'b1);
    step(); mem_req = 1'b1; mem_ready = 1'b0; s0 = stall_cnt; f0 = flush_cnt;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_frz", 32'({stall_if, stall_dec, stall_ex, stall_mem, bubble_wb, if_flush, dec_flush}),
             32'b1111100);
      step();
    end
    mem_req = 1'b0; br_taken = 1'b0;
`ifdef HAZARD_PERF_EN
    chk("t5_scnt", stall_cnt, s0 + 3);
    chk("t5_fcnt", flush_cnt, f0);
`endif
    #1 chk_flush("t5_r1", 1'b1, 1'b0);
    step(); #1 chk_flush("t5_r2", 1'b1, 1'b0);
    step(); #1 chk_flush("t5_r3", 1'b0, 1'b0);

    // 6: reset in FLUSH cycle 2, then a clean restart
    br_taken = 1'b1;
    step(); br_taken = 1'b0;
    step(); rst_n = 1'b0; set_rs(5'd4, 5'd0, 2'b01); mem_rd_addr = 5'd4; mem_reg_wr = 1'b1;
    #1 chk_flush("t6_rst", 1'b0, 1'b0); chk("t6_fwd", 32'(fwd_sel), 32'h0);
    step(); clear(); rst_n = 1'b1;
    #1 chk_flush("t6_idle", 1'b0, 1'b0);
    br_taken = 1'b1;
    #1 chk_flush("t6_br", 1'b1, 1'b1);
    step(); br_taken = 1'b0;
    #1 chk_flush("t6_c1", 1'b1, 1'b0);
    step(); #1 chk_flush("t6_c2", 1'b1, 1'b0);
    step(); #1 chk_flush("t6_c3", 1'b0, 1'b0);

    // 7: load-use in FLUSH masks branch, flush count still decrements
    br_taken = 1'b1;
    step(); set_rs(5'd9, 5'd0, 2'b01); mem_rd_addr = 5'd9; mem_reg_wr = 1'b1; mem_is_load = 1'b1;
    #1 chk_flush("t7_lu", 1'b1, 1'b0); chk("t7_bm", 32'(bubble_mem), 32'h1);
    step(); clear();
    #1 chk_flush("t7_c2", 1'b1, 1'b0);
    step(); #1 chk_flush("t7_c3", 1'b0, 1'b0);

    // 8: branch in FLUSH restarts the window
    br_taken = 1'b1;
    step(); #1 chk_flush("t8_re", 1'b1, 1'b1);
    step(); br_taken = 1'b0;
    #1 chk_flush("t8_c1", 1'b1, 1'b0);
    step(); #1 chk_flush("t8_c2", 1'b1, 1'b0);
    step(); #1 chk_flush("t8_c3", 1'b0, 1'b0);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
